prof_event_sampler: RTL and testbench

- Upstream producer for the profiling FIFO.
- Samples NUM_EVENTS single-cycle event pulses from the kernel under test and timestamps each with a free-running cycle counter.
- Emits one {eventId, timestamp} record per event through the FIFO's enqueue/back/full interface.
- Buffers one pending record per event line, inserts a wrap marker whenever the timestamp rolls over, and counts events it drops when the FIFO backs up.

---
 rtl/prof_event_sampler_if.sv | 11 +
 rtl/prof_event_sampler.sv | 141 ++++++++++++++
 tb/tb_prof_event_sampler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prof_event_sampler_if.sv
// Enqueue-side handshake between the event sampler and the profiling FIFO.
interface prof_event_sampler_if #(
  parameter int unsigned RecWidth = 32
) ();
  logic                enqueue;
  logic [RecWidth-1:0] back;
  logic                fifo_full;

  modport master (output enqueue, output back, input fifo_full);
  modport slave  (input enqueue, input back, output fifo_full);
endinterface

// File: rtl/prof_event_sampler.sv
// Timestamps single-cycle event pulses and feeds {id, ts} records into the profiling FIFO.
// One pending record per event line; a wrap marker (id all-ones, ts 0) is
// inserted on every timestamp rollover; lost occurrences are counted.
module prof_event_sampler #(
  parameter int unsigned NumEvents = 4,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned TsWidth   = 28,
  parameter int unsigned DropWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [NumEvents-1:0]  events_i,
  prof_event_sampler_if.master  fifo_io,
  output logic                  busy_o,
  output logic [DropWidth-1:0]  drop_count_o
);

  localparam int unsigned RecWidth = IdWidth + TsWidth;
  localparam logic [IdWidth-1:0]   WrapId  = '1;
  localparam logic [TsWidth-1:0]   TsOne   = {{(TsWidth-1){1'b0}}, 1'b1};
  localparam logic [DropWidth:0]   DropOne = {{DropWidth{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e               state_q, state_d;
  logic [TsWidth-1:0]   ts_q, ts_d;
  logic [NumEvents-1:0] pend_q, pend_d;
  logic [TsWidth-1:0]   lat_q [NumEvents];
  logic [TsWidth-1:0]   lat_d [NumEvents];
  logic                 wrap_q, wrap_d;
  logic [DropWidth-1:0] drop_q, drop_d;

  logic                 enq;
  logic [RecWidth-1:0]  rec;
  logic                 deq_wrap;
  logic [NumEvents-1:0] deq_ev;
  logic                 found;

  // Output arbitration: wrap marker first, then the lowest-index pending line.
  always_comb begin
    rec      = '0;
    deq_ev   = '0;
    deq_wrap = 1'b0;
    found    = 1'b0;
    enq      = (wrap_q | (|pend_q)) & ~fifo_io.fifo_full;
    if (wrap_q) begin
      rec      = {WrapId, {TsWidth{1'b0}}};
      deq_wrap = enq;
    end else begin
      for (int unsigned i = 0; i < NumEvents; i++) begin
        if (!found && pend_q[i]) begin
          found     = 1'b1;
          rec       = {IdWidth'(i), lat_q[i]};
          deq_ev[i] = enq;
        end
      end
    end
  end

  assign fifo_io.enqueue = enq;
  assign fifo_io.back    = rec;
  assign busy_o          = (state_q != StIdle);
  assign drop_count_o    = drop_q;

  logic [NumEvents-1:0] pend_after;
  logic                 wrap_after;
  logic [DropWidth:0]   drop_add;
  logic [DropWidth:0]   drop_sum;

  // Next-state: session FSM, timestamp, capture into per-line slots, drop accounting.
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    lat_d      = lat_q;
    // A slot being dequeued this cycle counts as free for a new occurrence.
    pend_after = pend_q & ~deq_ev;
    wrap_after = wrap_q & ~deq_wrap;
    pend_d     = pend_after;
    wrap_d     = wrap_after;
    drop_d     = drop_q;
    drop_add   = '0;
    drop_sum   = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          ts_d    = '0;
          drop_d  = '0;
          pend_d  = '0;
          wrap_d  = 1'b0;
        end
      end
      StRun: begin
        ts_d = ts_q + TsOne;
        if (&ts_q) begin
          if (wrap_after) drop_add = drop_add + DropOne;
          else            wrap_d   = 1'b1;
        end
        for (int unsigned i = 0; i < NumEvents; i++) begin
          if (events_i[i]) begin
            if (!pend_after[i]) begin
              pend_d[i] = 1'b1;
              lat_d[i]  = ts_q;
            end else begin
              drop_add = drop_add + DropOne;
            end
          end
        end
        drop_sum = {1'b0, drop_q} + drop_add;
        drop_d   = drop_sum[DropWidth] ? '1 : drop_sum[DropWidth-1:0];
        if (stop_i) state_d = StFlush;
      end
      StFlush: begin
        if (pend_after == '0 && !wrap_after) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ts_q    <= '0;
      pend_q  <= '0;
      wrap_q  <= 1'b0;
      drop_q  <= '0;
      for (int unsigned i = 0; i < NumEvents; i++) lat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      pend_q  <= pend_d;
      wrap_q  <= wrap_d;
      drop_q  <= drop_d;
      lat_q   <= lat_d;
    end
  end

endmodule

// File: tb/tb_prof_event_sampler.sv
// Directed plus randomized bench for prof_event_sampler, checked against a record-level model.
module tb_prof_event_sampler;

  localparam int N      = 4;
  localparam int IdW    = 4;
  localparam int TsW    = 4;
  localparam int DropW  = 5;
  localparam int RecW   = IdW + TsW;
  localparam int TsMod  = 1 << TsW;
  localparam int DropMax = (1 << DropW) - 1;
  localparam int WrapId = (1 << IdW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic [N-1:0]     events;
  logic             busy;
  logic [DropW-1:0] drop_count;

  prof_event_sampler_if #(.RecWidth(RecW)) fifo_if ();

  prof_event_sampler #(
    .NumEvents(N),
    .IdWidth  (IdW),
    .TsWidth  (TsW),
    .DropWidth(DropW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .stop_i      (stop),
    .events_i    (events),
    .fifo_io     (fifo_if),
    .busy_o      (busy),
    .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: 0 idle, 1 run, 2 flush; one record slot per line plus a wrap slot.
  int m_state;
  int m_ts;
  bit m_pend[N];
  int m_lat[N];
  bit m_wrap;
  int m_drop;

  logic [31:0] obs_enq, obs_back, obs_busy, obs_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ts    = 0;
    m_wrap  = 0;
    m_drop  = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_lat[i]  = 0;
    end
  endtask

  // sel: -1 wrap marker, 0..N-1 event line, -2 nothing offered.
  task automatic model_expect(input bit full, output bit e_enq, output int e_back,
                              output int sel);
    sel    = -2;
    e_back = 0;
    if (m_wrap) begin
      sel    = -1;
      e_back = WrapId * TsMod;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (m_pend[i]) begin
          sel    = i;
          e_back = i * TsMod + m_lat[i];
        end
      end
    end
    e_enq = (sel != -2) && !full;
  endtask

  task automatic model_step(input bit st, input bit sp, input logic [N-1:0] ev,
                            input bit e_enq, input int sel);
    int lost;
    lost = 0;
    if (e_enq) begin
      if (sel == -1) m_wrap = 0;
      else           m_pend[sel] = 0;
    end
    case (m_state)
      0: if (st) begin
        model_reset();
        m_state = 1;
      end
      1: begin
        for (int i = 0; i < N; i++) begin
          if (ev[i]) begin
            if (!m_pend[i]) begin
              m_pend[i] = 1;
              m_lat[i]  = m_ts;
            end else begin
              lost++;
            end
          end
        end
        if (m_ts == TsMod - 1) begin
          if (m_wrap) lost++;
          else        m_wrap = 1;
        end
        m_ts   = (m_ts + 1) % TsMod;
        m_drop = (m_drop + lost > DropMax) ? DropMax : m_drop + lost;
        if (sp) m_state = 2;
      end
      default: begin
        bit any;
        any = m_wrap;
        for (int i = 0; i < N; i++) any |= m_pend[i];
        if (!any) m_state = 0;
      end
    endcase
  endtask

  // One clock: drive mid-cycle, compare against the model, then advance the model at the edge.
  task automatic cycle(input bit st, input bit sp, input logic [N-1:0] ev, input bit fl);
    bit e_enq;
    int e_back;
    int sel;
    @(negedge clk);
    start             = st;
    stop              = sp;
    events            = ev;
    fifo_if.fifo_full = fl;
    #1;
    model_expect(fl, e_enq, e_back, sel);
    obs_enq  = 32'(fifo_if.enqueue);
    obs_back = 32'(fifo_if.back);
    obs_busy = 32'(busy);
    obs_drop = 32'(drop_count);
    check("enqueue", obs_enq, 32'(e_enq));
    check("back", obs_back, 32'(e_back));
    check("busy", obs_busy, 32'(m_state != 0));
    check("drop_count", obs_drop, 32'(m_drop));
    @(posedge clk);
    model_step(st, sp, ev, e_enq, sel);
  endtask

  task automatic run_to(input int ts, input bit fl);
    for (int k = 0; k < 2 * TsMod && m_ts != ts; k++) cycle(1'b0, 1'b0, '0, fl);
  endtask

  task automatic end_session();
    cycle(1'b0, 1'b1, '0, 1'b0);
    for (int k = 0; k < 20 && m_state != 0; k++) cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bit full_r;
    rst_n             = 1'b0;
    start             = 1'b0;
    stop              = 1'b0;
    events            = '0;
    fifo_if.fifo_full = 1'b0;
    model_reset();
    #3;
    check("rst_enqueue", 32'(fifo_if.enqueue), 32'd0);
    check("rst_back", 32'(fifo_if.back), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single event at ts=5.
    cycle(1'b1, 1'b0, '0, 1'b0);
    run_to(5, 1'b0);
    cycle(1'b0, 1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("single_enq", obs_enq, 32'd1);
    check("single_back", obs_back, 32'h05);
    check("single_drop", obs_drop, 32'd0);

    // Simultaneous events at ts=9 leave on consecutive cycles, lowest index first.
    run_to(9, 1'b0);
    cycle(1'b0, 1'b0, 4'b1010, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("simul_first", obs_back, 32'h19);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("simul_second", obs_back, 32'h39);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("simul_idle", obs_enq, 32'd0);
    end_session();

    // Backpressure: second occurrence on a pending line drops.
    cycle(1'b1, 1'b0, '0, 1'b1);
    run_to(3, 1'b1);
    cycle(1'b0, 1'b0, 4'b0100, 1'b1);
    run_to(6, 1'b1);
    cycle(1'b0, 1'b0, 4'b0100, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("bp_no_enq", obs_enq, 32'd0);
    check("bp_drop", obs_drop, 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("bp_release", obs_back, 32'h23);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("bp_only_one", obs_enq, 32'd0);
    end_session();

    // Wrap: marker precedes the pre-wrap record and the post-wrap one.
    cycle(1'b1, 1'b0, '0, 1'b0);
    run_to(15, 1'b0);
    cycle(1'b0, 1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 1'b0, 4'b0010, 1'b0);
    check("wrap_marker", obs_back, 32'hF0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("wrap_pre", obs_back, 32'h0F);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("wrap_post", obs_back, 32'h10);
    end_session();

    // Stop with records held back; flush ignores new events.
    cycle(1'b1, 1'b0, '0, 1'b1);
    run_to(2, 1'b1);
    cycle(1'b0, 1'b0, 4'b0011, 1'b1);
    cycle(1'b0, 1'b1, '0, 1'b1);
    cycle(1'b0, 1'b0, 4'b1111, 1'b1);
    check("flush_busy", obs_busy, 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("flush_rec0", obs_back, 32'h02);
    cycle(1'b0, 1'b0, 4'b0100, 1'b0);
    check("flush_rec1", obs_back, 32'h12);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("flush_idle", obs_busy, 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("restart_enq", obs_enq, 32'd1);
    check("restart_ts0", obs_back, 32'h00);

    // Asynchronous reset in the middle of a busy session.
    cycle(1'b0, 1'b0, 4'b0001, 1'b1);
    cycle(1'b0, 1'b0, 4'b0001, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("pre_rst_drop", obs_drop, 32'd1);
    @(negedge clk);
    fifo_if.fifo_full = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_enqueue", 32'(fifo_if.enqueue), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_drop", 32'(drop_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized sessions with bursty backpressure.
    full_r = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      logic [N-1:0] ev;
      if ($urandom_range(7) == 0) full_r = ~full_r;
      ev = N'($urandom) & N'($urandom);
      cycle(($urandom_range(15) == 0), ($urandom_range(40) == 0), ev, full_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
